// File: rtl/alloc_pkg.sv
// Shared flit and allocator-state types for the butterfly-switch output allocator.
package alloc_pkg;

  typedef enum logic [1:0] {
    NULL = 2'b00,
    TAIL = 2'b01,
    BODY = 2'b10,
    HEAD = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Flits that may continue a locked packet.
  function automatic logic is_payload(flit_type_e t);
    return (t == BODY) || (t == TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: lowest set request at or above ptr,
// wrapping, found by scanning a doubled request vector with the low part masked.
module rr_arbiter #(
  parameter int PORTS = 4,
  parameter int ADR_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [ADR_W-1:0] ptr,
  output logic [PORTS-1:0] gnt,
  output logic             any
);

  logic [2*PORTS-1:0] dbl_req;
  logic               found;

  always_comb begin
    dbl_req = {req, req};
    gnt     = '0;
    found   = 1'b0;
    for (int j = 0; j < 2*PORTS; j++) begin
      if (!found && dbl_req[j] && (j >= int'(ptr))) begin
        gnt[j % PORTS] = 1'b1;
        found          = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_packet_allocator.sv
// Output-port allocator: round-robin among HEAD requests addressed to r_adr,
// then holds the port for the winning input until its TAIL transfers.
module rr_packet_allocator
  import alloc_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int ADR_W = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADR_W-1:0]       r_adr,
  input  logic [PORTS-1:0]       in_valid,
  input  logic [2*PORTS-1:0]     in_type,
  input  logic [ADR_W*PORTS-1:0] in_dest,
  input  logic                   out_ready,
  output logic [PORTS-1:0]       sel,
  output logic                   shift,
  output logic [PORTS-1:0]       in_ack,
  output logic                   busy,
  output logic [ADR_W-1:0]       owner,
  output logic                   err
);

  alloc_state_e     state_q, state_d;
  logic [ADR_W-1:0] ptr_q, ptr_d;
  logic [ADR_W-1:0] owner_q, owner_d;
  logic             err_q, err_d;

  flit_type_e       typ [PORTS];
  logic [PORTS-1:0] req;
  logic [PORTS-1:0] gnt;
  logic             any;
  logic [ADR_W-1:0] g_idx;
  flit_type_e       own_typ;
  logic             own_vld;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      typ[i] = flit_type_e'(in_type[2*i +: 2]);
      req[i] = in_valid[i] && (typ[i] == HEAD) &&
               (in_dest[ADR_W*i +: ADR_W] == r_adr);
    end
  end

  rr_arbiter #(
    .PORTS (PORTS),
    .ADR_W (ADR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (any)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt[i]) g_idx = ADR_W'(i);
    end
    own_typ = typ[owner_q];
    own_vld = in_valid[owner_q];
  end

  // Select and transfer are combinational so a request is served the same cycle.
  always_comb begin
    sel   = '0;
    shift = 1'b0;
    if (rst_n) begin
      if (state_q == IDLE) begin
        sel   = gnt;
        shift = any && out_ready;
      end else begin
        sel[owner_q] = 1'b1;
        shift        = out_ready && own_vld && is_payload(own_typ);
      end
    end
    in_ack = sel & {PORTS{shift}};
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (shift) begin
          state_d = LOCKED;
          owner_d = g_idx;
          ptr_d   = g_idx + ADR_W'(1);
        end
      end
      LOCKED: begin
        if (shift && (own_typ == TAIL)) state_d = IDLE;
        // A second HEAD from the owner means the upstream lost a TAIL.
        if (own_vld && (own_typ == HEAD)) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == LOCKED);
  assign owner = owner_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rr_packet_allocator.sv
// Directed bench for rr_packet_allocator (PORTS=4, r_adr=2) with a packet-level
// reference model checked every cycle plus hand-computed literal expectations.
module tb_rr_packet_allocator;

  localparam int P  = 4;
  localparam int AW = 2;
  localparam logic [1:0] T_NULL = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_HEAD = 2'b11;
  localparam logic [AW-1:0] MY = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   r_adr;
  logic [P-1:0]    in_valid;
  logic [2*P-1:0]  in_type;
  logic [AW*P-1:0] in_dest;
  logic            out_ready;
  logic [P-1:0]    sel;
  logic            shift;
  logic [P-1:0]    in_ack;
  logic            busy;
  logic [AW-1:0]   owner;
  logic            err;

  int total = 0;
  int bad   = 0;

  rr_packet_allocator #(.PORTS(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_adr     (r_adr),
    .in_valid  (in_valid),
    .in_type   (in_type),
    .in_dest   (in_dest),
    .out_ready (out_ready),
    .sel       (sel),
    .shift     (shift),
    .in_ack    (in_ack),
    .busy      (busy),
    .owner     (owner),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: locked flag, owner, rotating pointer, sticky error.
  bit      m_locked;
  int      m_owner;
  int      m_ptr;
  bit      m_err;

  always @(negedge clk) begin
    logic [P-1:0] e_sel;
    logic         e_shift;
    int           g;
    logic [1:0]   ot;
    if (!rst_n) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_err = 0;
      chk("m_rst_sel", {28'd0, sel}, 32'd0);
      chk("m_rst_shift", {31'd0, shift}, 32'd0);
      chk("m_rst_ack", {28'd0, in_ack}, 32'd0);
      chk("m_rst_busy", {31'd0, busy}, 32'd0);
      chk("m_rst_err", {31'd0, err}, 32'd0);
    end else begin
      e_sel = '0; e_shift = 1'b0; g = -1;
      if (!m_locked) begin
        for (int k = 0; k < P; k++) begin
          int idx;
          idx = (m_ptr + k) % P;
          if (g < 0 && in_valid[idx] && in_type[2*idx +: 2] == T_HEAD &&
              in_dest[AW*idx +: AW] == r_adr) g = idx;
        end
        if (g >= 0) begin
          e_sel[g] = 1'b1;
          e_shift  = out_ready;
        end
      end else begin
        ot = in_type[2*m_owner +: 2];
        e_sel[m_owner] = 1'b1;
        e_shift = out_ready && in_valid[m_owner] && (ot == T_BODY || ot == T_TAIL);
      end
      chk("m_sel", {28'd0, sel}, {28'd0, e_sel});
      chk("m_shift", {31'd0, shift}, {31'd0, e_shift});
      chk("m_ack", {28'd0, in_ack}, {28'd0, e_sel & {P{e_shift}}});
      chk("m_busy", {31'd0, busy}, {31'd0, m_locked});
      chk("m_err", {31'd0, err}, {31'd0, m_err});
      if (m_locked) chk("m_owner", {30'd0, owner}, m_owner);
      if (!m_locked) begin
        if (e_shift) begin
          m_locked = 1; m_owner = g; m_ptr = (g + 1) % P;
        end
      end else begin
        ot = in_type[2*m_owner +: 2];
        if (e_shift && ot == T_TAIL) m_locked = 0;
        if (in_valid[m_owner] && ot == T_HEAD) m_err = 1;
      end
    end
  end

  task automatic set_ch(input int i, input logic v, input logic [1:0] t, input logic [AW-1:0] d);
    in_valid[i]        = v;
    in_type[2*i +: 2]  = t;
    in_dest[AW*i +: AW] = d;
  endtask

  task automatic clr_all();
    in_valid = '0; in_type = '0; in_dest = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  int          order[$];
  int          cnt [P];
  bit          phase [P];
  logic [P-1:0] acked;

  initial begin
    rst_n = 1'b0; r_adr = MY; out_ready = 1'b1; clr_all();
    for (int i = 0; i < P; i++) set_ch(i, 1'b1, T_HEAD, MY);
    @(negedge clk);
    chk("rst_sel_forced", {28'd0, sel}, 32'd0);
    chk("rst_shift_forced", {31'd0, shift}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    nxt(); rst_n = 1'b1; clr_all(); nxt();

    // Single packet from input 2.
    set_ch(2, 1'b1, T_HEAD, MY); @(negedge clk);
    chk("sp_head_sel", {28'd0, sel}, 32'b0100);
    chk("sp_head_shift", {31'd0, shift}, 32'd1);
    chk("sp_head_busy", {31'd0, busy}, 32'd0);
    nxt(); set_ch(2, 1'b1, T_BODY, 2'd0); @(negedge clk);
    chk("sp_body_sel", {28'd0, sel}, 32'b0100);
    chk("sp_body_shift", {31'd0, shift}, 32'd1);
    chk("sp_body_owner", {30'd0, owner}, 32'd2);
    nxt(); set_ch(2, 1'b1, T_TAIL, 2'd0); @(negedge clk);
    chk("sp_tail_ack", {28'd0, in_ack}, 32'b0100);
    nxt(); clr_all(); @(negedge clk);
    chk("sp_after_busy", {31'd0, busy}, 32'd0);
    // ptr is now 3: with everyone requesting and the output stalled, input 3 wins.
    out_ready = 1'b0;
    for (int i = 0; i < P; i++) set_ch(i, 1'b1, T_HEAD, MY);
    @(negedge clk);
    chk("sp_ptr3_sel", {28'd0, sel}, 32'b1000);
    nxt(); clr_all(); out_ready = 1'b1;

    // Fairness from ptr=0: continuous 2-flit packets on all inputs.
    rst_n = 1'b0; nxt(); rst_n = 1'b1;
    for (int i = 0; i < P; i++) begin phase[i] = 0; cnt[i] = 0; end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < P; i++) set_ch(i, 1'b1, phase[i] ? T_TAIL : T_HEAD, MY);
      @(negedge clk);
      acked = in_ack;
      for (int i = 0; i < P; i++) begin
        if (acked[i]) begin
          if (!phase[i]) begin order.push_back(i); cnt[i]++; end
          phase[i] = !phase[i];
        end
      end
      nxt();
    end
    clr_all();
    chk("fair_npkts", order.size(), 32'd8);
    for (int k = 0; k < 5; k++)
      chk("fair_order", (k < order.size()) ? order[k] : -1, k % P);
    for (int i = 0; i < P; i++) chk("fair_count", cnt[i], 32'd2);

    // Back-pressure: HEAD from input 1 stalled; input 0 joins mid-stall (ptr=0).
    out_ready = 1'b0; set_ch(1, 1'b1, T_HEAD, MY); @(negedge clk);
    chk("bp1_sel", {28'd0, sel}, 32'b0010);
    chk("bp1_shift", {31'd0, shift}, 32'd0);
    nxt(); set_ch(0, 1'b1, T_HEAD, MY); @(negedge clk);
    chk("bp2_sel", {28'd0, sel}, 32'b0001);
    chk("bp2_busy", {31'd0, busy}, 32'd0);
    nxt(); @(negedge clk);
    chk("bp3_shift", {31'd0, shift}, 32'd0);
    nxt(); out_ready = 1'b1; @(negedge clk);
    chk("bp_go_ack", {28'd0, in_ack}, 32'b0001);
    nxt(); set_ch(0, 1'b1, T_TAIL, MY); nxt();
    set_ch(0, 1'b0, T_NULL, 2'd0); @(negedge clk);
    chk("bp_in1_ack", {28'd0, in_ack}, 32'b0010);
    nxt(); set_ch(1, 1'b1, T_TAIL, MY); nxt(); clr_all();

    // Locked stall: input 3 owns the port and bubbles while input 0 requests.
    set_ch(3, 1'b1, T_HEAD, MY); nxt();
    set_ch(3, 1'b1, T_BODY, MY); nxt();
    set_ch(3, 1'b0, T_NULL, MY); set_ch(0, 1'b1, T_HEAD, MY);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("ls_sel", {28'd0, sel}, 32'b1000);
      chk("ls_shift", {31'd0, shift}, 32'd0);
      nxt();
    end
    set_ch(3, 1'b1, T_TAIL, MY); @(negedge clk);
    chk("ls_tail_ack", {28'd0, in_ack}, 32'b1000);
    nxt(); set_ch(3, 1'b0, T_NULL, 2'd0); @(negedge clk);
    chk("ls_next_ack", {28'd0, in_ack}, 32'b0001);
    nxt(); set_ch(0, 1'b1, T_TAIL, MY); nxt(); clr_all();

    // Protocol error: owner 1 presents a second HEAD.
    set_ch(1, 1'b1, T_HEAD, MY); nxt();
    @(negedge clk);
    chk("er_head_ack", {28'd0, in_ack}, 32'd0);
    chk("er_head_sel", {28'd0, sel}, 32'b0010);
    nxt(); set_ch(1, 1'b1, T_BODY, MY); @(negedge clk);
    chk("er_err", {31'd0, err}, 32'd1);
    chk("er_busy", {31'd0, busy}, 32'd1);
    nxt(); rst_n = 1'b0; @(negedge clk);
    chk("er_rst_err", {31'd0, err}, 32'd0);
    chk("er_rst_busy", {31'd0, busy}, 32'd0);
    nxt(); rst_n = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < P; i++) set_ch(i, 1'b1, T_HEAD, MY);
    @(negedge clk);
    chk("er_rst_ptr0", {28'd0, sel}, 32'b0001);
    nxt(); out_ready = 1'b1;

    // Misaddressed HEADs never request.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < P; i++) set_ch(i, 1'b1, T_HEAD, AW'((c + i) % 2 == 0 ? 1 : 3));
      if (c == 3) set_ch(2, 1'b1, T_HEAD, 2'd0);
      @(negedge clk);
      chk("mis_sel", {28'd0, sel}, 32'd0);
      chk("mis_shift", {31'd0, shift}, 32'd0);
      nxt();
    end
    clr_all(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
